pipe_ctrl: RTL and testbench

- Pipeline controller for the 5-stage RV32I core.
- Sequences the pc, if_id and id_ex registers around the decode stage: stalls, bubbles, flushes and multi-cycle holds.
- Resolves three hazard sources in priority order: ex-stage jump/branch redirect, multi-cycle execute unit busy, load-use dependency.
- Exposes stall/flush performance counters.

---
 rtl/core_pkg.sv | 16 +
 rtl/pipe_ctrl_if.sv | 46 ++++
 rtl/pipe_ctrl_sat_cnt.sv | 20 ++
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I pipeline control logic.
package core_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } pc_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Values loaded into the controller's registers on reset
  localparam pc_state_e RST_STATE   = RUN;
  localparam logic      RST_TIMEOUT = 1'b0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from id/ex and control outputs toward pc, if_id and id_ex.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             jump_en_i;
  logic [31:0]      jump_addr_i;
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_rs1_ren_i;
  logic             id_rs2_ren_i;
  logic [4:0]       ex_rd_addr_i;
  logic             ex_rd_wen_i;
  logic             ex_is_load_i;
  logic             mc_req_i;
  logic             mc_done_i;
  logic             pc_hold_o;
  logic             if_id_hold_o;
  logic             if_id_flush_o;
  logic             id_ex_hold_o;
  logic             id_ex_bubble_o;
  logic             pc_jump_en_o;
  logic [31:0]      pc_jump_addr_o;
  logic             mc_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Core side: produces hazard information, consumes control
  modport master (
    output jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_ren_i, id_rs2_ren_i, ex_rd_addr_i, ex_rd_wen_i,
           ex_is_load_i, mc_req_i, mc_done_i,
    input  pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o,
           id_ex_bubble_o, pc_jump_en_o, pc_jump_addr_o, mc_timeout_o,
           stall_cnt_o, flush_cnt_o
  );

  // Controller side
  modport slave (
    input  jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_ren_i, id_rs2_ren_i, ex_rd_addr_i, ex_rd_wen_i,
           ex_is_load_i, mc_req_i, mc_done_i,
    output pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o,
           id_ex_bubble_o, pc_jump_en_o, pc_jump_addr_o, mc_timeout_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: redirect, multi-cycle busy and load-use hazards.
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MC_MAX = 64,
  parameter int WD_W   = 7
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  pc_state_e        state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic             lu;
  logic             pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble;
  logic             jump_en;
  logic [31:0]      jump_addr;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // A load writing a non-zero rd that the id instruction actually reads
  assign lu = bus.ex_is_load_i & bus.ex_rd_wen_i & (bus.ex_rd_addr_i != REG_ZERO) &
              ((bus.id_rs1_ren_i & (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) |
               (bus.id_rs2_ren_i & (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

  // State, watchdog and sticky timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_STATE;
      wd_q      <= '0;
      timeout_q <= RST_TIMEOUT;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // Hazard resolution: redirect beats multi-cycle busy beats load-use
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    timeout_d    = timeout_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    jump_en      = 1'b0;
    jump_addr    = '0;
    case (state_q)
      RUN: begin
        if (bus.jump_en_i) begin
          // The id instruction is being killed, so its hazards do not matter
          jump_en      = 1'b1;
          jump_addr    = bus.jump_addr_i;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (bus.mc_req_i) begin
          if (!bus.mc_done_i) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
            wd_d       = WD_W'(1);
            state_d    = MC_WAIT;
          end
        end else if (lu) begin
          // One bubble is enough: next cycle the load value is forwarded from mem
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      MC_WAIT: begin
        // ex is frozen here, so redirect and load-use are not evaluated
        if (bus.mc_done_i) begin
          state_d = RUN;
          wd_d    = '0;
        end else if (wd_q == WD_W'(MC_MAX - 1)) begin
          timeout_d = 1'b1;
          wd_d      = '0;
          state_d   = RUN;
        end else begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          id_ex_hold = 1'b1;
          wd_d       = wd_q + WD_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    // Keep the pipeline quiet while reset is asserted
    if (rst) begin
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_hold   = 1'b0;
      id_ex_bubble = 1'b0;
      jump_en      = 1'b0;
      jump_addr    = '0;
    end
  end

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_hold),
    .count (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (jump_en),
    .count (flush_cnt)
  );

  assign bus.pc_hold_o      = pc_hold;
  assign bus.if_id_hold_o   = if_id_hold;
  assign bus.if_id_flush_o  = if_id_flush;
  assign bus.id_ex_hold_o   = id_ex_hold;
  assign bus.id_ex_bubble_o = id_ex_bubble;
  assign bus.pc_jump_en_o   = jump_en;
  assign bus.pc_jump_addr_o = jump_addr;
  assign bus.mc_timeout_o   = timeout_q;
  assign bus.stall_cnt_o    = stall_cnt;
  assign bus.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: main instance (32-bit counters) plus a
// 4-bit-counter instance sharing the same stimulus for saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en, rs1_ren, rs2_ren, ex_wen, ex_load, mc_req, mc_done;
  logic [31:0] jump_addr;
  logic [4:0]  rs1, rs2, ex_rd;
  int          errors = 0;
  int          checks = 0;
  int          hcnt;
  bit          done;

  // Cycles a watchdog-terminated wait holds: request cycle plus MC_WAIT
  // cycles with watchdog 1..62; release happens at watchdog 63.
  localparam int WD_HOLDS = 63;

  pipe_ctrl_if #(.CNT_W(32)) ifm ();
  pipe_ctrl_if #(.CNT_W(4))  ifs ();

  assign ifm.jump_en_i     = jump_en;
  assign ifm.jump_addr_i   = jump_addr;
  assign ifm.id_rs1_addr_i = rs1;
  assign ifm.id_rs2_addr_i = rs2;
  assign ifm.id_rs1_ren_i  = rs1_ren;
  assign ifm.id_rs2_ren_i  = rs2_ren;
  assign ifm.ex_rd_addr_i  = ex_rd;
  assign ifm.ex_rd_wen_i   = ex_wen;
  assign ifm.ex_is_load_i  = ex_load;
  assign ifm.mc_req_i      = mc_req;
  assign ifm.mc_done_i     = mc_done;
  assign ifs.jump_en_i     = jump_en;
  assign ifs.jump_addr_i   = jump_addr;
  assign ifs.id_rs1_addr_i = rs1;
  assign ifs.id_rs2_addr_i = rs2;
  assign ifs.id_rs1_ren_i  = rs1_ren;
  assign ifs.id_rs2_ren_i  = rs2_ren;
  assign ifs.ex_rd_addr_i  = ex_rd;
  assign ifs.ex_rd_wen_i   = ex_wen;
  assign ifs.ex_is_load_i  = ex_load;
  assign ifs.mc_req_i      = mc_req;
  assign ifs.mc_done_i     = mc_done;

  // {pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_bubble, pc_jump_en}
  wire [5:0] ctl = {ifm.pc_hold_o, ifm.if_id_hold_o, ifm.id_ex_hold_o,
                    ifm.if_id_flush_o, ifm.id_ex_bubble_o, ifm.pc_jump_en_o};

  pipe_ctrl #(.CNT_W(32), .MC_MAX(64), .WD_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifm.slave)
  );

  pipe_ctrl #(.CNT_W(4), .MC_MAX(64), .WD_W(7)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (ifs.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    jump_en = 1'b0; jump_addr = '0; rs1 = '0; rs2 = '0; rs1_ren = 1'b0;
    rs2_ren = 1'b0; ex_rd = '0; ex_wen = 1'b0; ex_load = 1'b0;
    mc_req = 1'b0; mc_done = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_load = 1'b1; ex_wen = 1'b1; ex_rd = rd; rs1 = rd; rs1_ren = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    set_lu(5'd5);
    jump_en = 1'b1; jump_addr = 32'h80;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL rst_ctl got=%b exp=000000", ctl); end
    checks++; if (ifm.pc_jump_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", ifm.pc_jump_addr_o); end
    checks++; if (ifm.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", ifm.stall_cnt_o); end
    checks++; if (ifm.flush_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_flush got=%0d exp=0", ifm.flush_cnt_o); end
    checks++; if (ifm.mc_timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", ifm.mc_timeout_o); end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    cyc();
    set_lu(5'd5);
    #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL lu_rs1 got=%b exp=110010", ctl); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_after got=%b exp=000000", ctl); end
    checks++; if (ifm.stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", ifm.stall_cnt_o); end
    set_lu(5'd0);
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_x0 got=%b exp=000000", ctl); end
    cyc();
    clear_inputs();
    ex_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd7; rs2 = 5'd7; rs2_ren = 1'b1; rs1 = 5'd3; rs1_ren = 1'b1;
    #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL lu_rs2 got=%b exp=110010", ctl); end
    cyc();
    rs2_ren = 1'b0;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_noren got=%b exp=000000", ctl); end
    cyc();
    clear_inputs();
    #1;
    checks++; if (ifm.stall_cnt_o !== 32'd2) begin errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", ifm.stall_cnt_o); end
  endtask

  task automatic test_jump_vs_lu();
    cyc();
    set_lu(5'd5);
    jump_en = 1'b1; jump_addr = 32'h80;
    #1;
    checks++; if (ctl !== 6'b000111) begin errors++; $display("FAIL jmp_ctl got=%b exp=000111", ctl); end
    checks++; if (ifm.pc_jump_addr_o !== 32'h80) begin errors++; $display("FAIL jmp_addr got=%h exp=00000080", ifm.pc_jump_addr_o); end
    cyc();
    clear_inputs();
    jump_addr = 32'h44;
    #1;
    checks++; if (ifm.pc_jump_addr_o !== 32'h0) begin errors++; $display("FAIL jmp_addr_idle got=%h exp=0", ifm.pc_jump_addr_o); end
    checks++; if (ifm.flush_cnt_o !== 32'd1) begin errors++; $display("FAIL jmp_flush_cnt got=%0d exp=1", ifm.flush_cnt_o); end
    checks++; if (ifm.stall_cnt_o !== 32'd2) begin errors++; $display("FAIL jmp_stall_cnt got=%0d exp=2", ifm.stall_cnt_o); end
    clear_inputs();
  endtask

  task automatic test_multi_cycle();
    cyc();
    mc_req = 1'b1;
    #1;
    checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL mc_req_cycle got=%b exp=111000", ctl); end
    for (int i = 1; i < 33; i++) begin
      cyc();
      jump_en = (i == 16);
      jump_addr = (i == 16) ? 32'h200 : 32'h0;
      #1;
      checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL mc_wait_%0d got=%b exp=111000", i, ctl); end
    end
    cyc();
    jump_en = 1'b0; jump_addr = '0;
    mc_done = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL mc_done_cycle got=%b exp=000000", ctl); end
    cyc();
    mc_req = 1'b0; mc_done = 1'b0;
    set_lu(5'd5);
    #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL mc_back_run got=%b exp=110010", ctl); end
    checks++; if (ifm.stall_cnt_o !== 32'd35) begin errors++; $display("FAIL mc_stall_cnt got=%0d exp=35", ifm.stall_cnt_o); end
    checks++; if (ifm.flush_cnt_o !== 32'd1) begin errors++; $display("FAIL mc_flush_cnt got=%0d exp=1", ifm.flush_cnt_o); end
    cyc();
    clear_inputs();
  endtask

  task automatic test_watchdog();
    cyc();
    mc_req = 1'b1;
    hcnt = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (ifm.pc_hold_o === 1'b1) hcnt++;
      else done = 1'b1;
      if (!done) cyc();
    end
    checks++; if (!done) begin errors++; $display("FAIL wd_release got=none exp=release"); end
    checks++; if (hcnt !== WD_HOLDS) begin errors++; $display("FAIL wd_holds got=%0d exp=%0d", hcnt, WD_HOLDS); end
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL wd_release_ctl got=%b exp=000000", ctl); end
    checks++; if (ifm.mc_timeout_o !== 1'b0) begin errors++; $display("FAIL wd_timeout_early got=%b exp=0", ifm.mc_timeout_o); end
    cyc();
    mc_req = 1'b0;
    set_lu(5'd5);
    #1;
    checks++; if (ifm.mc_timeout_o !== 1'b1) begin errors++; $display("FAIL wd_timeout got=%b exp=1", ifm.mc_timeout_o); end
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL wd_back_run got=%b exp=110010", ctl); end
    checks++; if (ifm.stall_cnt_o !== 32'd99) begin errors++; $display("FAIL wd_stall_cnt got=%0d exp=99", ifm.stall_cnt_o); end
    cyc();
    clear_inputs();
    repeat (3) cyc();
    #1;
    checks++; if (ifm.mc_timeout_o !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", ifm.mc_timeout_o); end
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    mc_req = 1'b1;
    repeat (10) cyc();
    rst = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL rmw_ctl_in_rst got=%b exp=000000", ctl); end
    cyc();
    rst = 1'b0;
    mc_req = 1'b1; mc_done = 1'b1;
    #1;
    checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL rmw_req_done got=%b exp=000000", ctl); end
    checks++; if (ifm.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rmw_stall got=%0d exp=0", ifm.stall_cnt_o); end
    checks++; if (ifm.flush_cnt_o !== 32'd0) begin errors++; $display("FAIL rmw_flush got=%0d exp=0", ifm.flush_cnt_o); end
    checks++; if (ifm.mc_timeout_o !== 1'b0) begin errors++; $display("FAIL rmw_timeout got=%b exp=0", ifm.mc_timeout_o); end
    cyc();
    clear_inputs();
    set_lu(5'd9);
    #1;
    checks++; if (ctl !== 6'b110010) begin errors++; $display("FAIL rmw_run got=%b exp=110010", ctl); end
    cyc();
    clear_inputs();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_lu(5'd5);
    repeat (20) cyc();
    #1;
    checks++; if (ifs.stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_small got=%0d exp=15", ifs.stall_cnt_o); end
    checks++; if (ifm.stall_cnt_o !== 32'd20) begin errors++; $display("FAIL sat_main got=%0d exp=20", ifm.stall_cnt_o); end
    repeat (2) cyc();
    #1;
    checks++; if (ifs.stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_small_hold got=%0d exp=15", ifs.stall_cnt_o); end
    checks++; if (ifm.stall_cnt_o !== 32'd22) begin errors++; $display("FAIL sat_main_hold got=%0d exp=22", ifm.stall_cnt_o); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jump_vs_lu();
    test_multi_cycle();
    test_watchdog();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
